// File: rtl/sr_pkg.sv
// Shared definitions for the shift-register serial controller.
//  - CMD_*      : {c1,c0} command codes understood by the universal shift register
//  - sr_state_e : controller FSM states
//  - state_ctrl : Moore decode of a state into the register's {en, c1, c0} pins
package sr_pkg;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_SHR  = 2'b01;
  localparam logic [1:0] CMD_SHL  = 2'b10;
  localparam logic [1:0] CMD_LOAD = 2'b11;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StShift = 3'd2,
    StHold  = 3'd3,
    StGap   = 3'd4
  } sr_state_e;

  function automatic logic [2:0] state_ctrl(sr_state_e st);
    logic [2:0] ctrl;
    ctrl = {1'b0, CMD_HOLD};
    case (st)
      StLoad:  ctrl = {1'b1, CMD_LOAD};
      StShift: ctrl = {1'b1, CMD_SHR};
      default: ctrl = {1'b0, CMD_HOLD};
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/sr_serial_ctrl_if.sv
// Byte handshake between a data source and sr_serial_ctrl.
//  tx_data  : byte to send (source -> controller)
//  tx_valid : tx_data valid (source -> controller)
//  tx_ready : controller can accept a byte (controller -> source)
interface sr_serial_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sr_bit_timer.sv
// Loadable down-counter timing the HOLD and GAP phases.
//  clk, rst : clock and synchronous active-high reset
//  load     : capture load_val (takes priority over counting)
//  load_val : start value; the phase lasts load_val+1 cycles
//  count    : current count
//  tc       : terminal count, high while count is zero
module sr_bit_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign count = cnt_q;
  assign tc    = (cnt_q == '0);

endmodule

// File: rtl/sr_serial_ctrl.sv
// Sequencer for an 8-bit universal shift register: accepts a byte, parallel-loads it, then shifts
// it right WIDTH times and emits the register flag (the bit shifted out) as an LSB-first stream.
//  sr_clk, sr_rst        : clock and synchronous active-high reset
//  tx                    : byte handshake (tx_data / tx_valid / tx_ready)
//  srdata_in             : captured byte for the register's parallel input
//  sr_en, sr_c1, sr_c0   : register enable and command
//  sr_flag               : register flag (bit shifted out of the LSB)
//  ser_out, ser_valid    : registered serial bit and its one-cycle strobe
//  done                  : pulse with the last bit's strobe
//  busy                  : high whenever not idle
module sr_serial_ctrl
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             sr_clk,
  input  logic             sr_rst,
  sr_serial_ctrl_if.slave  tx,
  output logic [WIDTH-1:0] srdata_in,
  output logic             sr_en,
  output logic             sr_c1,
  output logic             sr_c0,
  input  logic             sr_flag,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done,
  output logic             busy
);

  localparam int unsigned TmrMax = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;
  localparam int unsigned CntW   = $clog2(WIDTH);

  localparam logic [TmrW-1:0] HoldLd  = TmrW'(BIT_CYCLES - 1);
  localparam logic [TmrW-1:0] GapLd   = (GAP_CYCLES > 0) ? TmrW'(GAP_CYCLES - 1) : '0;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  sr_state_e       state_q;
  logic [CntW-1:0] bit_cnt_q;
  logic            tmr_load;
  logic [TmrW-1:0] tmr_val;
  logic [TmrW-1:0] tmr_count;
  logic            tmr_tc;
  logic            last_bit;
  logic            first_hold;
  logic [2:0]      ctrl;

  assign last_bit   = (bit_cnt_q == LastBit);
  // The timer is loaded with HoldLd on the way into HOLD, so that value marks the first cycle.
  assign first_hold = (tmr_count == HoldLd);

  // SHIFT always arms the HOLD timer; the last HOLD arms the GAP timer when a gap exists.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = HoldLd;
    if (state_q == StShift) begin
      tmr_load = 1'b1;
    end else if (state_q == StHold && tmr_tc && last_bit && GAP_CYCLES != 0) begin
      tmr_load = 1'b1;
      tmr_val  = GapLd;
    end
  end

  sr_bit_timer #(
    .W (TmrW)
  ) u_timer (
    .clk      (sr_clk),
    .rst      (sr_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .tc       (tmr_tc)
  );

  always_ff @(posedge sr_clk) begin
    if (sr_rst) begin
      state_q   <= StIdle;
      srdata_in <= '0;
      bit_cnt_q <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      ser_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tx.tx_valid) begin
            srdata_in <= tx.tx_data;
            bit_cnt_q <= '0;
            state_q   <= StLoad;
          end
        end
        StLoad:  state_q <= StShift;
        StShift: state_q <= StHold;
        StHold: begin
          // The flag was updated by the preceding SHIFT edge, so it is stable here.
          if (first_hold) begin
            ser_out   <= sr_flag;
            ser_valid <= 1'b1;
            done      <= last_bit;
          end
          if (tmr_tc) begin
            if (last_bit) begin
              state_q <= (GAP_CYCLES == 0) ? StIdle : StGap;
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
              state_q   <= StShift;
            end
          end
        end
        StGap: begin
          if (tmr_tc) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ctrl                  = state_ctrl(state_q);
  assign {sr_en, sr_c1, sr_c0} = ctrl;
  assign tx.tx_ready           = (state_q == StIdle);
  assign busy                  = (state_q != StIdle);

endmodule

// File: tb/tb_sr_serial_ctrl.sv
// Bench for sr_serial_ctrl: two controllers (BIT=1/GAP=1 and BIT=3/GAP=0) each driving a
// behavioural universal shift register. Accepted bytes push expected bits into a scoreboard;
// every ser_valid strobe pops and checks value, done flag and timing.
module tb_sr_serial_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_serial_ctrl_if #(.WIDTH(8)) ifa ();
  sr_serial_ctrl_if #(.WIDTH(8)) ifb ();

  logic [7:0] srd [2];
  logic       en [2], c1 [2], c0 [2], flag [2];
  logic       so [2], sv [2], dn [2], bsy [2];
  logic       rdy [2], vld [2];
  logic [7:0] dat [2];
  logic [7:0] sr [2];

  assign rdy[0] = ifa.tx_ready;
  assign rdy[1] = ifb.tx_ready;
  assign vld[0] = ifa.tx_valid;
  assign vld[1] = ifb.tx_valid;
  assign dat[0] = ifa.tx_data;
  assign dat[1] = ifb.tx_data;

  sr_serial_ctrl #(.WIDTH(8), .BIT_CYCLES(1), .GAP_CYCLES(1)) u_dut_a (
    .sr_clk (clk), .sr_rst (rst), .tx (ifa), .srdata_in (srd[0]),
    .sr_en (en[0]), .sr_c1 (c1[0]), .sr_c0 (c0[0]), .sr_flag (flag[0]),
    .ser_out (so[0]), .ser_valid (sv[0]), .done (dn[0]), .busy (bsy[0])
  );

  sr_serial_ctrl #(.WIDTH(8), .BIT_CYCLES(3), .GAP_CYCLES(0)) u_dut_b (
    .sr_clk (clk), .sr_rst (rst), .tx (ifb), .srdata_in (srd[1]),
    .sr_en (en[1]), .sr_c1 (c1[1]), .sr_c0 (c0[1]), .sr_flag (flag[1]),
    .ser_out (so[1]), .ser_valid (sv[1]), .done (dn[1]), .busy (bsy[1])
  );

  // Behavioural universal shift register: 00 hold, 01 shr, 10 shl, 11 load.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        sr[k]   <= 8'h00;
        flag[k] <= 1'b0;
      end else if (en[k]) begin
        case ({c1[k], c0[k]})
          2'b01: begin sr[k] <= {1'b0, sr[k][7:1]}; flag[k] <= sr[k][0]; end
          2'b10: begin sr[k] <= {sr[k][6:0], 1'b0}; flag[k] <= sr[k][7]; end
          2'b11: sr[k] <= srd[k];
          default: ;
        endcase
      end
    end
  end

  typedef struct {
    int   inst;
    int   idx;
    logic b;
    logic d;
  } sb_t;

  sb_t sbq[$];
  sb_t e, p;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_load [2] = '{0, 0};
  int n_shr [2] = '{0, 0};
  int n_shl [2] = '{0, 0};
  int n_done [2] = '{0, 0};
  int n_strobe [2] = '{0, 0};
  int n_acc [2] = '{0, 0};
  int acc_cyc [2] = '{0, 0};
  int last_cyc [2] = '{0, 0};
  int period [2] = '{2, 4};
  int refc, gap_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        case ({en[k], c1[k], c0[k]})
          3'b111: n_load[k]++;
          3'b101: n_shr[k]++;
          3'b110: n_shl[k]++;
          default: ;
        endcase
        if (dn[k] === 1'b1) n_done[k]++;
      end
      if (sv[k] === 1'b1) begin
        n_chk++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL strobe_unexpected inst %0d: ser_valid high with empty scoreboard", k);
        end else begin
          e = sbq.pop_front();
          if (e.inst != k || so[k] !== e.b || dn[k] !== e.d) begin
            n_fail++;
            $display("FAIL scoreboard_bit inst %0d idx %0d: got ser_out=%b done=%b, expected inst %0d ser_out=%b done=%b",
                     k, e.idx, so[k], dn[k], e.inst, e.b, e.d);
          end
          n_chk++;
          gap_e = (e.idx == 0) ? 4 : period[k];
          refc  = (e.idx == 0) ? acc_cyc[k] : last_cyc[k];
          if (cyc - refc != gap_e) begin
            n_fail++;
            $display("FAIL strobe_timing inst %0d idx %0d: got %0d cycles, expected %0d",
                     k, e.idx, cyc - refc, gap_e);
          end
          last_cyc[k] = cyc;
        end
        n_strobe[k]++;
      end else if (dn[k] === 1'b1) begin
        n_chk++;
        n_fail++;
        $display("FAIL done_without_strobe inst %0d: done=1 ser_valid=0", k);
      end
      if (!rst && vld[k] === 1'b1 && rdy[k] === 1'b1) begin
        for (int i = 0; i < 8; i++) begin
          p.inst = k;
          p.idx  = i;
          p.b    = dat[k][i];
          p.d    = (i == 7);
          sbq.push_back(p);
        end
        acc_cyc[k] = cyc;
        n_acc[k]++;
      end
    end
    if (rst) sbq.delete();
  end

  task automatic set_tx(input int k, input logic v, input logic [7:0] d);
    if (k == 0) begin
      ifa.tx_valid = v;
      ifa.tx_data  = d;
    end else begin
      ifb.tx_valid = v;
      ifb.tx_data  = d;
    end
  endtask

  // Present a byte, wait (bounded) for it to be taken, then drop tx_valid.
  task automatic send(input int k, input logic [7:0] d, output logic ok);
    int base;
    base = n_acc[k];
    @(posedge clk); #1;
    set_tx(k, 1'b1, d);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (n_acc[k] != base) break;
    end
    ok = (n_acc[k] != base);
    @(posedge clk); #1;
    set_tx(k, 1'b0, 8'h00);
  endtask

  // Cycles from the accept sample to the first cycle tx_ready is high again; -1 on timeout.
  task automatic wait_idle(input int k, output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (rdy[k] === 1'b1) begin
        lat = cyc - acc_cyc[k];
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [23:0] got;
    set_tx(0, 1'b0, 8'h00);
    set_tx(1, 1'b0, 8'h00);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      got = {srd[k], so[k], sv[k], dn[k], bsy[k], rdy[k], en[k], c1[k], c0[k], sr[k]};
      n_chk++;
      if (got !== {8'h00, 8'b0000_1000, 8'h00}) begin
        n_fail++;
        $display("FAIL reset_state inst %0d: got %h, expected %h", k, got,
                 {8'h00, 8'b0000_1000, 8'h00});
      end
    end
  endtask

  task automatic test_frame_a5;
    logic ok;
    int lat, s0, d0;
    n_load[0] = 0; n_shr[0] = 0; n_shl[0] = 0;
    s0 = n_strobe[0]; d0 = n_done[0];
    send(0, 8'hA5, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL a5_accept: got no accept, expected accept"); end
    wait_idle(0, lat);
    n_chk++;
    if (lat != 19) begin n_fail++; $display("FAIL a5_ready_latency: got %0d, expected 19", lat); end
    n_chk++;
    if (n_strobe[0] - s0 != 8) begin
      n_fail++; $display("FAIL a5_strobes: got %0d, expected 8", n_strobe[0] - s0);
    end
    n_chk++;
    if (n_done[0] - d0 != 1) begin
      n_fail++; $display("FAIL a5_done_count: got %0d, expected 1", n_done[0] - d0);
    end
    n_chk++;
    if (n_load[0] != 1 || n_shr[0] != 8 || n_shl[0] != 0) begin
      n_fail++;
      $display("FAIL a5_cmd_trace: got load=%0d shr=%0d shl=%0d, expected 1 8 0",
               n_load[0], n_shr[0], n_shl[0]);
    end
    n_chk++;
    if (sr[0] !== 8'h00) begin n_fail++; $display("FAIL a5_sr_final: got %h, expected 00", sr[0]); end
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL a5_sb_empty: got %0d pending, expected 0", sbq.size());
    end
  endtask

  task automatic test_back_to_back;
    int a1, a2, base, lat, s0, d0;
    s0 = n_strobe[0]; d0 = n_done[0];
    base = n_acc[0];
    @(posedge clk); #1;
    set_tx(0, 1'b1, 8'hFF);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (n_acc[0] != base) break;
    end
    a1 = acc_cyc[0];
    @(posedge clk); #1;
    set_tx(0, 1'b1, 8'h01);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (n_acc[0] != base + 1) break;
    end
    a2 = acc_cyc[0];
    @(posedge clk); #1;
    set_tx(0, 1'b0, 8'h00);
    n_chk++;
    if (n_acc[0] - base != 2 || a2 - a1 != 19) begin
      n_fail++;
      $display("FAIL b2b_second_accept: got %0d accepts %0d cycles apart, expected 2 and 19",
               n_acc[0] - base, a2 - a1);
    end
    wait_idle(0, lat);
    n_chk++;
    if (lat != 19) begin n_fail++; $display("FAIL b2b_ready_latency: got %0d, expected 19", lat); end
    n_chk++;
    if (n_strobe[0] - s0 != 16 || n_done[0] - d0 != 2) begin
      n_fail++;
      $display("FAIL b2b_counts: got strobes=%0d done=%0d, expected 16 2",
               n_strobe[0] - s0, n_done[0] - d0);
    end
    n_chk++;
    if (so[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_last_bit: got %b, expected 0", so[0]); end
  endtask

  task automatic test_slow_bits;
    logic ok;
    int lat, s0, d0, r0;
    s0 = n_strobe[1]; d0 = n_done[1]; r0 = n_shr[1];
    send(1, 8'h80, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL slow_accept: got no accept, expected accept"); end
    wait_idle(1, lat);
    n_chk++;
    if (lat != 34) begin n_fail++; $display("FAIL slow_ready_latency: got %0d, expected 34", lat); end
    n_chk++;
    if (n_strobe[1] - s0 != 8 || n_done[1] - d0 != 1 || n_shr[1] - r0 != 8) begin
      n_fail++;
      $display("FAIL slow_counts: got strobes=%0d done=%0d shr=%0d, expected 8 1 8",
               n_strobe[1] - s0, n_done[1] - d0, n_shr[1] - r0);
    end
    n_chk++;
    if (so[1] !== 1'b1) begin n_fail++; $display("FAIL slow_last_bit: got %b, expected 1", so[1]); end
    n_chk++;
    if (sr[1] !== 8'h00) begin n_fail++; $display("FAIL slow_sr_final: got %h, expected 00", sr[1]); end
  endtask

  task automatic test_reset_mid_frame;
    logic ok;
    logic [23:0] got;
    int holds, lat, s0, d0;
    s0 = n_strobe[0]; d0 = n_done[0];
    send(0, 8'h3C, ok);
    holds = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bsy[0] === 1'b1 && en[0] === 1'b0) holds++;
      if (holds == 4) break;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    got = {srd[0], so[0], sv[0], dn[0], bsy[0], rdy[0], en[0], c1[0], c0[0], sr[0]};
    n_chk++;
    if (holds != 4 || got !== {8'h00, 8'b0000_1000, 8'h00}) begin
      n_fail++;
      $display("FAIL midrst_state: got holds=%0d state %h, expected 4 and %h", holds, got,
               {8'h00, 8'b0000_1000, 8'h00});
    end
    n_chk++;
    if (n_strobe[0] - s0 != 3 || n_done[0] - d0 != 0) begin
      n_fail++;
      $display("FAIL midrst_partial: got strobes=%0d done=%0d, expected 3 0",
               n_strobe[0] - s0, n_done[0] - d0);
    end
    s0 = n_strobe[0]; d0 = n_done[0];
    send(0, 8'h3C, ok);
    wait_idle(0, lat);
    n_chk++;
    if (!ok || lat != 19) begin
      n_fail++; $display("FAIL midrst_refresh: got accept=%b latency=%0d, expected 1 19", ok, lat);
    end
    n_chk++;
    if (n_strobe[0] - s0 != 8 || n_done[0] - d0 != 1 || sr[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_refresh_counts: got strobes=%0d done=%0d sr=%h, expected 8 1 00",
               n_strobe[0] - s0, n_done[0] - d0, sr[0]);
    end
  endtask

  task automatic test_valid_during_reset;
    int base;
    base = n_acc[0];
    @(posedge clk); #1;
    rst = 1'b1;
    set_tx(0, 1'b1, 8'hFF);
    @(posedge clk); #1;
    rst = 1'b0;
    set_tx(0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      n_chk++;
      if (bsy[0] !== 1'b0) begin
        n_fail++; $display("FAIL vrst_busy cycle %0d: got %b, expected 0", i, bsy[0]);
      end
    end
    n_chk++;
    if (n_acc[0] != base) begin
      n_fail++; $display("FAIL vrst_accept: got %0d accepts, expected 0", n_acc[0] - base);
    end
  endtask

  initial begin
    set_tx(0, 1'b0, 8'h00);
    set_tx(1, 1'b0, 8'h00);
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_slow_bits();
    test_reset_mid_frame();
    test_valid_during_reset();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
